calc_sequencer: RTL and testbench

//  Command sequencer between the numpad scanner and the operand stack. Debounces the
//  5-bit key code, turns each press into exactly one single-cycle stack command
//  (write/push/pop + value) and checks stack depth before any operation. Replaces

---
 rtl/calc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_calc_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Command sequencer between the numpad scanner and the operand stack.
// Debounces the key code, issues exactly one stack command per press and
// refuses operations the stack cannot legally perform.
module calc_sequencer #(
  parameter int WIDTH    = 32,
  parameter int COUNT_W  = 6,
  parameter int DEPTH    = 32,
  parameter int DEBOUNCE = 250000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [4:0]         key,
  input  logic [WIDTH-1:0]   top,
  input  logic [WIDTH-1:0]   next,
  input  logic [COUNT_W-1:0] count,
  output logic               write,
  output logic               push,
  output logic               pop,
  output logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               fault
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0]   REL_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] TWO_C    = COUNT_W'(2);
  localparam logic [2*WIDTH-1:0] TEN      = (2*WIDTH)'(10);

  typedef enum logic [1:0] {
    IDLE,
    STABLE,
    EXEC,
    RELEASE
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [3:0]         code, code_nx;
  logic [4:0]         key_q;
  logic               write_nx, push_nx, pop_nx, fault_nx;
  logic [WIDTH-1:0]   value_nx;

  logic               is_digit;
  logic [3:0]         digit;
  logic [2*WIDTH-1:0] wide_top;
  logic [2*WIDTH-1:0] wide_entry;

  // Map the scanner's button index onto a decimal digit, if it is one.
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      4'h0:    digit = 4'd1;
      4'h1:    digit = 4'd4;
      4'h2:    digit = 4'd7;
      4'h3:    digit = 4'd0;
      4'h4:    digit = 4'd2;
      4'h5:    digit = 4'd5;
      4'h6:    digit = 4'd8;
      4'h8:    digit = 4'd3;
      4'h9:    digit = 4'd6;
      4'hA:    digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // Digit entry is computed double-width so overflow is visible in the upper half.
  always_comb begin
    wide_top   = {{WIDTH{1'b0}}, top};
    wide_entry = wide_top * TEN + {{(2*WIDTH-4){1'b0}}, digit};
  end

  // Next-state, debounce counter and registered command outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = code;
    write_nx = 1'b0;
    push_nx  = 1'b0;
    pop_nx   = 1'b0;
    value_nx = '0;
    fault_nx = fault;
    case (state)
      IDLE: begin
        if (key_q[4]) begin
          state_nx = STABLE;
          cnt_nx   = CNT_ONE;
          code_nx  = key_q[3:0];
        end
      end
      STABLE: begin
        if (!key_q[4]) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (key_q[3:0] != code) begin
          code_nx = key_q[3:0];
          cnt_nx  = CNT_ONE;
        end else if (cnt == DEB_LAST) begin
          state_nx = EXEC;
          cnt_nx   = '0;
          if (is_digit) begin
            if (wide_entry[2*WIDTH-1:WIDTH] != '0) begin
              fault_nx = 1'b1;
            end else begin
              write_nx = 1'b1;
              value_nx = wide_entry[WIDTH-1:0];
              fault_nx = 1'b0;
            end
          end else if (code == 4'hC) begin
            if (count < DEPTH_C) begin
              push_nx  = 1'b1;
              fault_nx = 1'b0;
            end else begin
              fault_nx = 1'b1;
            end
          end else if (code == 4'hD || code == 4'hE || code == 4'hF) begin
            if (count >= TWO_C) begin
              write_nx = 1'b1;
              pop_nx   = 1'b1;
              fault_nx = 1'b0;
              case (code)
                4'hD:    value_nx = next + top;
                4'hE:    value_nx = next - top;
                default: value_nx = next * top;
              endcase
            end else begin
              fault_nx = 1'b1;
            end
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      EXEC: begin
        state_nx = RELEASE;
        cnt_nx   = '0;
      end
      RELEASE: begin
        if (key_q[4]) begin
          cnt_nx = '0;
        end else if (cnt == REL_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register plus the input sync stage and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
      key_q <= '0;
      write <= 1'b0;
      push  <= 1'b0;
      pop   <= 1'b0;
      value <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      code  <= code_nx;
      key_q <= key;
      write <= write_nx;
      push  <= push_nx;
      pop   <= pop_nx;
      value <= value_nx;
      fault <= fault_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: presses queue expected commands,
// a negedge monitor pops and compares them when the DUT acts.
module tb_calc_sequencer;

  localparam int WIDTH   = 32;
  localparam int COUNT_W = 6;
  localparam int DEPTH   = 4;
  localparam int DEB     = 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [4:0]         key = '0;
  logic [WIDTH-1:0]   top = '0;
  logic [WIDTH-1:0]   next = '0;
  logic [COUNT_W-1:0] count = '0;
  logic               write, push, pop, busy, fault;
  logic [WIDTH-1:0]   value;

  calc_sequencer #(
    .WIDTH(WIDTH), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .DEBOUNCE(DEB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .key(key), .top(top), .next(next),
    .count(count), .write(write), .push(push), .pop(pop), .value(value),
    .busy(busy), .fault(fault)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          has;
    logic        w, p, o, f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  bit   model_fault = 1'b0;
  int   digit_tab[16] = '{1, 4, 7, 0, 2, 5, 8, -1, 3, 6, 9, -1, -1, -1, -1, -1};

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, wanted %0h", name, got, want);
  endtask

  // Reference: what a press should do, straight from the command rules.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] t, input logic [31:0] n,
                                 input int cv, input bit fp);
    exp_t r;
    longint unsigned acc;
    int d;
    r.due = 0; r.has = 0; r.w = 0; r.p = 0; r.o = 0; r.v = '0; r.f = fp;
    d = digit_tab[c];
    if (d >= 0) begin
      acc = {32'b0, t};
      acc = acc * 10 + longint'(d);
      if (acc > 64'hFFFF_FFFF) r.f = 1;
      else begin r.has = 1; r.w = 1; r.v = acc[31:0]; r.f = 0; end
    end else if (c == 4'hC) begin
      if (cv < DEPTH) begin r.has = 1; r.p = 1; r.f = 0; end
      else r.f = 1;
    end else if (c == 4'hD || c == 4'hE || c == 4'hF) begin
      if (cv >= 2) begin
        r.has = 1; r.w = 1; r.o = 1; r.f = 0;
        if (c == 4'hD) r.v = n + t;
        else if (c == 4'hE) r.v = n - t;
        else r.v = n * t;
      end else r.f = 1;
    end
    return r;
  endfunction

  // Monitor: compare each strobe (or each due refusal) against the queue head.
  always @(negedge clock) begin
    if (reset_n) begin
      if (write | push | pop) begin
        if (sb.size() == 0 || !sb[0].has) begin
          checkOutput("unexpected_strobe", {61'b0, write, push, pop}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("strobe_cycle", 64'(cyc), 64'(mon_e.due));
          checkOutput("strobe_data", {28'b0, write, push, pop, fault, value},
                      {28'b0, mon_e.w, mon_e.p, mon_e.o, mon_e.f, mon_e.v});
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        mon_e = sb.pop_front();
        checkOutput("no_strobe_cmd", {60'b0, write, push, pop, fault},
                    {60'b0, mon_e.w, mon_e.p, mon_e.o, mon_e.f});
      end
    end
  end

  task automatic expectPress(input logic [3:0] c);
    exp_t e;
    e = model(c, top, next, int'(count), model_fault);
    e.due = cyc + DEB + 2;
    model_fault = e.f;
    sb.push_back(e);
  endtask

  task automatic releaseAndIdle();
    key = '0;
    repeat (DEB) @(posedge clock);
    #1 checkOutput("busy_release_wait", {63'b0, busy}, 64'd1);
    @(posedge clock);
    #1 checkOutput("busy_idle", {63'b0, busy}, 64'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] t, input logic [31:0] n,
                               input logic [5:0] cv, input int hold);
    @(posedge clock);
    #1;
    top = t; next = n; count = cv;
    key = {1'b1, c};
    expectPress(c);
    repeat (hold) @(posedge clock);
    #1 checkOutput("busy_held", {63'b0, busy}, 64'd1);
    releaseAndIdle();
  endtask

  task automatic resetCheck(input string name);
    reset_n = 1'b0;
    #1 checkOutput(name, {27'b0, write, push, pop, fault, busy, value}, 64'd0);
    model_fault = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    expectPress(key[3:0]);
    repeat (DEB + 4) @(posedge clock);
    #1 releaseAndIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] rt;
    int          sel;
    repeat (3) @(posedge clock);
    #1 checkOutput("reset_state", {27'b0, write, push, pop, fault, busy, value}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // held digit 4 on top=12, no repeat while held
    applyStimulus(4'h1, 32'd12, 32'd0, 6'd1, 20);

    // bouncing '1' then a steady '2'
    repeat (3) begin
      @(posedge clock); #1 key = 5'b10000;
      @(posedge clock); @(posedge clock); #1 key = 5'b00000;
      @(posedge clock);
    end
    applyStimulus(4'h4, 32'd7, 32'd0, 6'd1, DEB + 3);

    // binary operator depth and wrap
    applyStimulus(4'hD, 32'd5, 32'd7, 6'd1, DEB + 2);
    applyStimulus(4'hE, 32'd5, 32'd7, 6'd2, DEB + 2);
    applyStimulus(4'hE, 32'd5, 32'd3, 6'd2, DEB + 2);

    // push against full and not-full stack
    applyStimulus(4'hC, 32'd1, 32'd1, 6'd4, DEB + 2);
    applyStimulus(4'hC, 32'd1, 32'd1, 6'd3, DEB + 2);

    // digit overflow and multiply truncation
    applyStimulus(4'h3, 32'hFFFF_FFFF, 32'd0, 6'd1, DEB + 2);
    applyStimulus(4'hF, 32'h0001_0000, 32'h0001_0000, 6'd2, DEB + 2);
    applyStimulus(4'h7, 32'd9, 32'd0, 6'd2, DEB + 2);

    // reset while debouncing, key held through release
    @(posedge clock); #1;
    top = 32'd3; count = 6'd1; key = 5'b10001;
    repeat (3) @(posedge clock);
    #1 checkOutput("busy_stable", {63'b0, busy}, 64'd1);
    resetCheck("reset_in_stable");

    // reset in the strobe cycle, with fault previously set
    applyStimulus(4'hC, 32'd0, 32'd0, 6'd4, DEB + 2);
    @(posedge clock); #1;
    top = 32'd5; count = 6'd1; key = 5'b10011;
    repeat (DEB + 2) @(posedge clock);
    #1 checkOutput("exec_reached", {31'b0, write, value}, {31'b0, 1'b1, 32'd50});
    resetCheck("reset_in_exec");

    // randomized presses
    for (int i = 0; i < 40; i++) begin
      rc  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 2);
      if (sel == 0) rt = $urandom_range(0, 1000);
      else if (sel == 1) rt = $urandom;
      else rt = 32'h1999_9999 + 32'($urandom_range(0, 2));
      applyStimulus(rc, rt, $urandom, 6'($urandom_range(0, DEPTH)), DEB + 2 + $urandom_range(0, 8));
    end

    repeat (DEB + 10) @(posedge clock);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checkOutput("unserved_expectation", 64'(mon_e.due), 64'(-1));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
